// File: rtl/store_commit_unit.sv
// store_commit_unit: round-robin arbiter committing one of two ready store slots to memory, then releasing its tag
module store_commit_unit #(
  parameter int ST1_TAG = 9,
  parameter int ST2_TAG = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   st_ready_bus,
  input  logic [127:0] st_addr,
  input  logic [127:0] st_data,
  input  logic         mem_wr_ack,
  output logic         mem_wr_req,
  output logic [63:0]  mem_addr,
  output logic [63:0]  mem_wdata,
  output logic         free_tag_flag,
  output logic [3:0]   free_this_tag,
  output logic         scu_busy,
  output logic [15:0]  stores_done
);
  typedef enum logic [1:0] {IDLE, REQ, FREE, HOLD} state_t;
  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d, data_q, data_d;
  logic [3:0]  tag_q, tag_d;
  logic [15:0] done_q, done_d;
  logic        last_q, last_d;
  logic        pick1;
  always_comb begin
    pick1   = st_ready_bus[1] && (!st_ready_bus[0] || !last_q);
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tag_d   = tag_q;
    done_d  = done_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (|st_ready_bus) begin
        state_d = REQ;
        addr_d  = pick1 ? st_addr[63:0] : st_addr[127:64];
        data_d  = pick1 ? st_data[63:0] : st_data[127:64];
        tag_d   = pick1 ? 4'(ST1_TAG) : 4'(ST2_TAG);
        last_d  = pick1;
      end
      REQ: if (mem_wr_ack) begin
        state_d = FREE;
        done_d  = done_q + 16'd1;
      end
      FREE:    state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      done_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end
  assign mem_wr_req    = state_q == REQ;
  assign mem_addr      = addr_q;
  assign mem_wdata     = data_q;
  assign free_tag_flag = state_q == FREE;
  assign free_this_tag = state_q == FREE ? tag_q : 4'd0;
  assign scu_busy      = state_q != IDLE;
  assign stores_done   = done_q;
endmodule

// File: tb/tb_store_commit_unit.sv
// tb_store_commit_unit: directed self-checking bench for store_commit_unit
module tb_store_commit_unit;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   st_ready_bus = '0;
  logic [127:0] st_addr = '0;
  logic [127:0] st_data = '0;
  logic         mem_wr_ack = 1'b0;
  logic         mem_wr_req;
  logic [63:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic         free_tag_flag;
  logic [3:0]   free_this_tag;
  logic         scu_busy;
  logic [15:0]  stores_done;
  int n_cmp = 0;
  int n_err = 0;
  store_commit_unit dut (
    .clk(clk), .rst(rst), .st_ready_bus(st_ready_bus), .st_addr(st_addr),
    .st_data(st_data), .mem_wr_ack(mem_wr_ack), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .free_tag_flag(free_tag_flag),
    .free_this_tag(free_this_tag), .scu_busy(scu_busy), .stores_done(stores_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic store(input logic [1:0] rdy, input logic [3:0] etag, input logic [15:0] edone,
                       input logic [63:0] eaddr, input logic [63:0] edata);
    st_ready_bus = rdy;
    mem_wr_ack = 1'b1;
    tick();
    chk("req", 64'(mem_wr_req), 64'd1);
    chk("addr", mem_addr, eaddr);
    chk("wdata", mem_wdata, edata);
    chk("req_busy", 64'(scu_busy), 64'd1);
    chk("req_noflag", 64'(free_tag_flag), 64'd0);
    tick();
    chk("free_req", 64'(mem_wr_req), 64'd0);
    chk("free_flag", 64'(free_tag_flag), 64'd1);
    chk("free_tag", 64'(free_this_tag), 64'(etag));
    chk("free_done", 64'(stores_done), 64'(edone));
    tick();
    chk("hold_flag", 64'(free_tag_flag), 64'd0);
    chk("hold_tag", 64'(free_this_tag), 64'd0);
    chk("hold_busy", 64'(scu_busy), 64'd1);
    tick();
    chk("idle_busy", 64'(scu_busy), 64'd0);
  endtask
  initial begin
    st_addr = {64'h200, 64'h100};
    st_data = {64'hCD, 64'hAB};
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req", 64'(mem_wr_req), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_flag", 64'(free_tag_flag), 64'd0);
    chk("rst_tag", 64'(free_this_tag), 64'd0);
    chk("rst_busy", 64'(scu_busy), 64'd0);
    chk("rst_done", 64'(stores_done), 64'd0);
    store(2'b10, 4'd9, 16'd1, 64'h100, 64'hAB);
    st_ready_bus = 2'b00;
    mem_wr_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_done", 64'(stores_done), 64'd0);
    store(2'b11, 4'd9, 16'd1, 64'h100, 64'hAB);
    store(2'b11, 4'd10, 16'd2, 64'h200, 64'hCD);
    store(2'b11, 4'd9, 16'd3, 64'h100, 64'hAB);
    store(2'b11, 4'd10, 16'd4, 64'h200, 64'hCD);
    st_ready_bus = 2'b10;
    mem_wr_ack = 1'b0;
    tick();
    st_ready_bus = 2'b00;
    st_data[63:0] = 64'hFF;
    chk("stall_req1", 64'(mem_wr_req), 64'd1);
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk($sformatf("stall_req%0d", i), 64'(mem_wr_req), 64'd1);
      chk($sformatf("stall_wdata%0d", i), mem_wdata, 64'hAB);
      chk($sformatf("stall_flag%0d", i), 64'(free_tag_flag), 64'd0);
    end
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
    chk("stall_flag", 64'(free_tag_flag), 64'd1);
    chk("stall_tag", 64'(free_this_tag), 64'd9);
    chk("stall_done", 64'(stores_done), 64'd5);
    tick();
    chk("stall_hold_flag", 64'(free_tag_flag), 64'd0);
    tick();
    chk("stall_idle", 64'(scu_busy), 64'd0);
    chk("stall_done2", 64'(stores_done), 64'd5);
    mem_wr_ack = 1'b1;
    tick();
    chk("stray_busy", 64'(scu_busy), 64'd0);
    chk("stray_flag", 64'(free_tag_flag), 64'd0);
    chk("stray_req", 64'(mem_wr_req), 64'd0);
    tick();
    chk("stray_done", 64'(stores_done), 64'd5);
    mem_wr_ack = 1'b0;
    st_data[63:0] = 64'hAB;
    st_ready_bus = 2'b01;
    tick();
    chk("mid_req", 64'(mem_wr_req), 64'd1);
    chk("mid_addr", mem_addr, 64'h200);
    rst = 1'b1;
    mem_wr_ack = 1'b1;
    st_ready_bus = 2'b11;
    tick();
    rst = 1'b0;
    mem_wr_ack = 1'b0;
    st_ready_bus = 2'b00;
    chk("mid_rst_req", 64'(mem_wr_req), 64'd0);
    chk("mid_rst_busy", 64'(scu_busy), 64'd0);
    chk("mid_rst_done", 64'(stores_done), 64'd0);
    chk("mid_rst_flag", 64'(free_tag_flag), 64'd0);
    tick();
    chk("mid_rst_flag2", 64'(free_tag_flag), 64'd0);
    chk("mid_rst_busy2", 64'(scu_busy), 64'd0);
    force dut.done_q = 16'hFFFE;
    #1;
    release dut.done_q;
    store(2'b10, 4'd9, 16'hFFFF, 64'h100, 64'hAB);
    store(2'b10, 4'd9, 16'h0000, 64'h100, 64'hAB);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
